// File: rtl/mem_seq_if.sv
// rtl/mem_seq_if.sv - request/response handshake and SRAM strobe bundle for mem_seq
interface mem_seq_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  // CPU-side request
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;

  // CPU-side response and status
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  // Mem2IO / SRAM side
  logic [ADDR_W-1:0] ADDR;
  logic              CE;
  logic              UB;
  logic              LB;
  logic              OE;
  logic              WE;
  logic [DATA_W-1:0] Data_to_Mem;
  logic [DATA_W-1:0] Data_from_Mem;

  // The sequencer itself
  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, Data_from_Mem,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output ADDR, CE, UB, LB, OE, WE, Data_to_Mem
  );

  // The requester / memory side
  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, Data_from_Mem,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  ADDR, CE, UB, LB, OE, WE, Data_to_Mem
  );
endinterface

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - single-word SRAM access sequencer with registered active-low strobes
module mem_seq #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16
) (
  input  logic      Clk,
  input  logic      Reset,
  mem_seq_if.slave  bus
);

  // A zero-wait build would leave no strobe-low cycle at all, so clamp to one.
  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = (WC > 1) ? $clog2(WC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_q, rsp_d;
  logic              ce_q, ce_d;
  logic              ub_q, ub_d;
  logic              lb_q, lb_d;
  logic              oe_q, oe_d;
  logic              wr_q, wr_d;

  // Sequencing: accept in IDLE, one setup cycle, WC access cycles, one hold cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_SETUP;
          we_d    = bus.req_we;
          be_d    = bus.req_be;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = CNT_LOAD;
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = bus.Data_from_Mem;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are derived from the state being entered so they change on the same edge
  // as the state register and come straight out of flops (no decode glitches).
  always_comb begin
    ce_d  = 1'b1;
    ub_d  = 1'b1;
    lb_d  = 1'b1;
    oe_d  = 1'b1;
    wr_d  = 1'b1;
    rsp_d = (state_d == S_DONE);
    if (state_d != S_IDLE) begin
      ce_d = 1'b0;
      ub_d = ~be_d[1];
      lb_d = ~be_d[0];
    end
    case (state_d)
      S_SETUP: begin
        oe_d = we_d;
      end
      S_ACCESS: begin
        oe_d = we_d;
        wr_d = ~we_d;
      end
      default: begin
      end
    endcase
  end

  // State, latched request and output registers; reset drops any in-flight access.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
      ce_q    <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      oe_q    <= 1'b1;
      wr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
      ce_q    <= ce_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      oe_q    <= oe_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.rsp_valid   = rsp_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.ADDR        = addr_q;
  assign bus.Data_to_Mem = wdata_q;
  assign bus.CE          = ce_q;
  assign bus.UB          = ub_q;
  assign bus.LB          = lb_q;
  assign bus.OE          = oe_q;
  assign bus.WE          = wr_q;

endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - scoreboard bench for mem_seq with SRAM/switch model
module tb_mem_seq;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mem_seq_if #(.ADDR_W(20), .DATA_W(16)) bus ();
  mem_seq_if #(.ADDR_W(20), .DATA_W(16)) bus0 ();

  mem_seq #(.WAIT_CYCLES(2), .ADDR_W(20), .DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave)
  );

  mem_seq #(.WAIT_CYCLES(0), .ADDR_W(20), .DATA_W(16)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(bus0.slave)
  );

  // SRAM model with byte lanes; xFFFF reads the switches and ignores writes
  logic [15:0] mem [0:255];
  logic [15:0] switches;
  assign switches = 16'h0F0F;
  assign bus.Data_from_Mem  = (bus.ADDR == 20'hFFFF) ? switches : mem[bus.ADDR[7:0]];
  assign bus0.Data_from_Mem = 16'h0000;

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'h1111;
    end else if (!bus.CE && !bus.WE && bus.ADDR != 20'hFFFF) begin
      if (!bus.UB) mem[bus.ADDR[7:0]][15:8] <= bus.Data_to_Mem[15:8];
      if (!bus.LB) mem[bus.ADDR[7:0]][7:0]  <= bus.Data_to_Mem[7:0];
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        rd;
    logic [1:0]  be;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  // Drive a request from a negedge and hold it until accepted; returns the accept edge.
  task automatic issue(input logic we, input logic [1:0] be, input logic [19:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd, output int acc);
    int n;
    exp_t e;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 40), 1);
    acc     = cyc + 1;
    e.rd    = !we;
    e.be    = be;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = exp_rd;
    e.acc   = acc;
    sb_q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    while ((bus.busy || sb_q.size() != 0) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("idle_in_time", 32'(n < 40), 1);
    @(negedge Clk);
  endtask

  // Monitor: accumulates strobe behaviour per transaction, checks it on rsp_valid
  initial begin : monitor
    exp_t e;
    int ce_n, oe_n, we_n, ub_n, lb_n;
    logic first_we, addr_ok, data_ok, prev_busy, prev_rsp;
    logic [19:0] addr0;
    logic [15:0] data0;
    prev_busy = 1'b0;
    prev_rsp  = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_busy = 1'b0;
        prev_rsp  = 1'b0;
      end else begin
        if (bus.req_ready === bus.busy) chk("ready_vs_busy", bus.req_ready, !bus.busy);
        if (bus.busy && !prev_busy) begin
          ce_n = 0; oe_n = 0; we_n = 0; ub_n = 0; lb_n = 0;
          first_we = bus.WE;
          addr0 = bus.ADDR;
          data0 = bus.Data_to_Mem;
          addr_ok = 1'b1;
          data_ok = 1'b1;
        end
        if (bus.busy) begin
          if (!bus.CE) ce_n++;
          if (!bus.OE) oe_n++;
          if (!bus.WE) we_n++;
          if (!bus.UB) ub_n++;
          if (!bus.LB) lb_n++;
          if (bus.ADDR !== addr0) addr_ok = 1'b0;
          if (bus.Data_to_Mem !== data0) data_ok = 1'b0;
        end
        if (bus.rsp_valid) begin
          chk("rsp_single_pulse", prev_rsp, 0);
          if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL rsp_unexpected: rsp_valid seen with no outstanding request, expected none");
          end else begin
            e = sb_q.pop_front();
            chk("latency", cyc - e.acc, 3);
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("addr", addr0, e.addr);
            chk("data_to_mem", data0, e.wdata);
            chk("addr_stable", addr_ok, 1);
            chk("data_stable", data_ok, 1);
            chk("ce_low_cycles", ce_n, 4);
            chk("oe_low_cycles", oe_n, e.rd ? 3 : 0);
            chk("we_low_cycles", we_n, e.rd ? 0 : 2);
            chk("ub_low_cycles", ub_n, e.be[1] ? 4 : 0);
            chk("lb_low_cycles", lb_n, e.be[0] ? 4 : 0);
            chk("we_high_at_ce_fall", first_we, 1);
            chk("we_high_in_hold", bus.WE, 1);
          end
        end
        prev_busy = bus.busy;
        prev_rsp  = bus.rsp_valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int a1, a2, a3, a4, a5;
    logic [5:0] exp0 [0:3];
    exp0[0] = 6'b010110;  // SETUP : CE UB LB OE WE rsp
    exp0[1] = 6'b010100;  // ACCESS
    exp0[2] = 6'b010111;  // DONE
    exp0[3] = 6'b111110;  // IDLE

    Reset = 1'b1;
    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_be = 2'b00;
    bus.req_addr  = '0;    bus.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_be = 2'b00;
    bus0.req_addr  = '0;   bus0.req_wdata = '0;
    repeat (3) @(negedge Clk);

    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes", {bus.CE, bus.UB, bus.LB, bus.OE, bus.WE}, 5'b11111);
    chk("rst_addr", bus.ADDR, 0);
    chk("rst_dtm", bus.Data_to_Mem, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    Reset = 1'b0;
    @(negedge Clk);

    issue(1'b0, 2'b11, 20'h00010, 16'h0000, 16'hBEEF, a1); wait_idle();
    issue(1'b1, 2'b11, 20'h00010, 16'h1234, 16'hBEEF, a1); wait_idle();
    issue(1'b0, 2'b11, 20'h00010, 16'h0000, 16'h1234, a1); wait_idle();
    repeat (3) @(negedge Clk);
    chk("rdata_hold_idle", bus.rsp_rdata, 16'h1234);
    issue(1'b1, 2'b11, 20'hFFFF, 16'h00A5, 16'h1234, a1); wait_idle();
    issue(1'b0, 2'b11, 20'hFFFF, 16'h0000, 16'h0F0F, a1); wait_idle();
    issue(1'b1, 2'b01, 20'h00020, 16'hABCD, 16'h0F0F, a1); wait_idle();
    issue(1'b0, 2'b11, 20'h00020, 16'h0000, 16'h11CD, a1); wait_idle();
    issue(1'b1, 2'b00, 20'h00020, 16'h9999, 16'h11CD, a1); wait_idle();
    issue(1'b0, 2'b00, 20'h00020, 16'h0000, 16'h11CD, a1); wait_idle();

    // req_valid held high across alternating write/read
    issue(1'b1, 2'b11, 20'h00030, 16'h5A5A, 16'h11CD, a1);
    issue(1'b0, 2'b11, 20'h00030, 16'h0000, 16'h5A5A, a2);
    chk("spacing_1", a2 - a1, 5);
    issue(1'b1, 2'b10, 20'h00031, 16'hC3C3, 16'h5A5A, a3);
    chk("spacing_2", a3 - a2, 5);
    issue(1'b0, 2'b11, 20'h00031, 16'h0000, 16'hC300, a4);
    chk("spacing_3", a4 - a3, 5);
    wait_idle();

    // Reset during the second ACCESS cycle of a write
    issue(1'b1, 2'b11, 20'h00040, 16'h7777, 16'hC300, a5);
    bus.req_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("pre_reset_we_low", bus.WE, 0);
    #1 Reset = 1'b1;
    #1;
    chk("async_rst_we", bus.WE, 1);
    chk("async_rst_ce", bus.CE, 1);
    chk("async_rst_ready", bus.req_ready, 1);
    sb_q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    chk("post_rst_ready", bus.req_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_addr", bus.ADDR, 0);
    chk("post_rst_rdata", bus.rsp_rdata, 0);

    // WAIT_CYCLES=0 build, lower-byte write
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b1;
    bus0.req_be    = 2'b01;
    bus0.req_addr  = 20'h00005;
    bus0.req_wdata = 16'h55AA;
    chk("wc0_ready", bus0.req_ready, 1);
    @(negedge Clk);
    bus0.req_valid = 1'b0;
    bus0.req_wdata = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wc0_vec%0d", i),
          {bus0.CE, bus0.UB, bus0.LB, bus0.OE, bus0.WE, bus0.rsp_valid}, exp0[i]);
      if (i < 3) chk($sformatf("wc0_dtm%0d", i), bus0.Data_to_Mem, 16'h55AA);
      @(negedge Clk);
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
